// File: rtl/necpu_pkg.sv
// Shared NECPU definitions: instruction width, NOP encoding and the boot FSM
// states of the loadable instruction memory.
package necpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    LOAD
  } boot_state_e;

endpackage

// File: rtl/inst_mem_ram.sv
// 1R1W synchronous RAM with registered read and no reset; maps onto
// distributed or block RAM.
module inst_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable NECPU instruction memory: boot FSM zero-fills the RAM, then serves
// registered fetches and accepts streamed program loads from the host.
module inst_mem_loadable
  import necpu_pkg::*;
#(
  parameter int                 DATA_W   = INST_W,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_en,
  input  logic [31:0]                  address,
  output logic [DATA_W-1:0]            inst,
  output logic                         inst_valid,
  output logic                         addr_err,
  output logic                         cpu_hold,
  input  logic                         load_start,
  input  logic                         prog_valid,
  input  logic [DATA_W-1:0]            prog_data,
  input  logic                         load_done,
  output logic [$clog2(DEPTH+1)-1:0]   load_count,
  output logic                         load_ovf
);

  localparam int                AW      = $clog2(DEPTH);
  localparam int                CW      = $clog2(DEPTH + 1);
  localparam logic [31:0]       DEPTH_W = DEPTH;
  localparam logic [AW-1:0]     LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0]     FULL    = CW'(DEPTH);

  boot_state_e       state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     load_count_q, load_count_d;
  logic              load_ovf_q, load_ovf_d;
  logic              inst_valid_q, inst_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              inst_nop_q, inst_nop_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              in_range;

  assign in_range = (address < DEPTH_W);

  // The RAM has no reset, so a flag selects NOP_WORD until a real in-range read lands.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_ovf_d   = load_ovf_q;
    inst_valid_d = 1'b0;
    addr_err_d   = addr_err_q;
    inst_nop_d   = inst_nop_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = ptr_q;
    ram_wdata    = NOP_WORD;

    unique case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (load_start) begin
          state_d      = LOAD;
          load_count_d = '0;
          load_ovf_d   = 1'b0;
        end else if (fetch_en) begin
          inst_valid_d = 1'b1;
          addr_err_d   = ~in_range;
          inst_nop_d   = ~in_range;
          ram_re       = in_range;
        end
      end
      LOAD: begin
        ram_wdata = prog_data;
        ram_waddr = AW'(load_count_q);
        if (load_start) begin
          load_count_d = '0;
          load_ovf_d   = 1'b0;
          if (prog_valid) begin
            ram_we       = 1'b1;
            ram_waddr    = '0;
            load_count_d = CW'(1);
          end
        end else begin
          if (prog_valid) begin
            if (load_count_q < FULL) begin
              ram_we       = 1'b1;
              load_count_d = load_count_q + CW'(1);
            end else begin
              load_ovf_d = 1'b1;
            end
          end
          if (load_done) state_d = RUN;
        end
      end
      default: state_d = CLEAR;
    endcase

    cpu_hold_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      load_count_q <= '0;
      load_ovf_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      inst_nop_q   <= 1'b1;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      load_ovf_q   <= load_ovf_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      inst_nop_q   <= inst_nop_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  inst_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (address[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign inst       = inst_nop_q ? NOP_WORD : ram_rdata;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_count = load_count_q;
  assign load_ovf   = load_ovf_q;

endmodule
